// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA engine: one accepted request at a time, busy while shifting, done pulse with result.
// Optional ISU_FAST4_EN: shifts by 4 per cycle while at least 4 positions remain.
module iterative_shift_unit #(
  parameter int dataWidth  = 32,
  parameter int shamtWidth = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            op,
  input  logic [dataWidth-1:0]  dataIn,
  input  logic [shamtWidth-1:0] shamt,
  output logic                  busy,
  output logic                  done,
  output logic [dataWidth-1:0]  rdataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t                       state, state_nxt;
  logic signed [dataWidth-1:0]  acc, acc_nxt;
  logic [shamtWidth-1:0]        count, count_nxt;
  logic [1:0]                   op_r, op_nxt;
  logic [dataWidth-1:0]         rdata_nxt;
  logic                         accept;

  // Reserved op 2'b11 falls into the default arm and behaves as SLL.
  function automatic logic signed [dataWidth-1:0] shift1(
    input logic signed [dataWidth-1:0] a,
    input logic [1:0]                  o
  );
    case (o)
      OP_SRL:  shift1 = a >> 1;
      OP_SRA:  shift1 = a >>> 1;
      default: shift1 = a << 1;
    endcase
  endfunction

`ifdef ISU_FAST4_EN
  function automatic logic signed [dataWidth-1:0] shift4(
    input logic signed [dataWidth-1:0] a,
    input logic [1:0]                  o
  );
    case (o)
      OP_SRL:  shift4 = a >> 4;
      OP_SRA:  shift4 = a >>> 4;
      default: shift4 = a << 4;
    endcase
  endfunction
`endif

  assign accept = start && !flush && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    op_nxt    = op_r;

    case (state)
      SHIFT: begin
        if (count == '0) begin
          // Unreachable guard so count can never wrap below zero.
          state_nxt = DONE;
        end else begin
`ifdef ISU_FAST4_EN
          if (count >= shamtWidth'(4)) begin
            acc_nxt   = shift4(acc, op_r);
            count_nxt = count - shamtWidth'(4);
          end else begin
            acc_nxt   = shift1(acc, op_r);
            count_nxt = count - shamtWidth'(1);
          end
          if (count_nxt == '0) state_nxt = DONE;
`else
          acc_nxt   = shift1(acc, op_r);
          count_nxt = count - shamtWidth'(1);
          if (count == shamtWidth'(1)) state_nxt = DONE;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        if (accept) begin
          acc_nxt   = $signed(dataIn);
          count_nxt = shamt;
          op_nxt    = op;
          state_nxt = (shamt != '0) ? SHIFT : DONE;
        end
      end
    endcase

    if (flush) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end

    // Result is captured only on the edge that enters DONE.
    rdata_nxt = (state_nxt == DONE) ? dataWidth'(acc_nxt) : rdataOut;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      op_r     <= 2'b00;
      rdataOut <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      op_r     <= op_nxt;
      rdataOut <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    acc <= acc_nxt;
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
